paralelo_serial_tx: RTL and testbench
=====================================

Name: paralelo_serial_tx

Overview:
- Transmit-side parallel-to-serial stage. Sits directly upstream of the serial-to-parallel receiver and drives its serial input.
- Accepts bytes through a valid/ready handshake and serialises them MSB-first, one bit per clk_32f.
- When no data is available, it fills the line with the comma byte 0xBC. The receiver needs these commas to reach byte alignment and lock.
- After reset it sends a guaranteed preamble of commas before any data byte is allowed onto the line.

Parameters:
- COMMA, 8'hBC: idle/alignment byte sent when no data is pending.
- MIN_COMMAS, 4: number of commas sent after reset before data may be sent. Legal range 1..15.

Ports:
- clk_32f  input  1  bit clock; all state changes on the rising edge
- reset_L  input  1  reset, asynchronous, active-low
- data_in  input  8  parallel byte to transmit
- valid_in  input  1  data_in is valid this cycle
- ready_in  output  1  block can accept a byte this cycle
- data_out  output  1  serial line to the receiver, MSB first
- valid_out  output  1  byte currently on the line is data (1) or comma (0)
- byte_start  output  1  one-cycle pulse while bit 7 of each byte is on data_out
- active  output  1  preamble complete; data may be sent

Behaviour:
- Reset (reset_L=0, takes effect immediately, asynchronous):
  - shift_reg=8'h00, bit_cnt=7, hold_full=0, hold_reg=0, comma_cnt=0, state=SYNC.
  - Outputs: data_out=0, valid_out=0, byte_start=0, active=0, ready_in=1.
- Output derivation:
  - data_out = shift_reg[7], taken directly from the register.
  - Each clock, the register shifts left by one with 0 filled in at the bottom.
  - bit_cnt decrements and wraps 0→7.
- Load edge: a rising edge with bit_cnt==0, or the first edge after reset (bit_cnt==7 with the reset flag set). Simpler equivalent: reset bit_cnt to 0, so the first edge after reset is a load edge. The following rules assume this.
- At each load edge, shift_reg takes the next byte and bit_cnt becomes 7. The next byte is:
  - state RUN and hold_full=1: hold_reg. Set valid_out=1 and clear hold_full, unless a new byte is accepted in the same cycle.
  - otherwise: COMMA. Set valid_out=0.
  - byte_start=1 for the cycle following every load edge; 0 at all other times.
- State machine:
  - SYNC → RUN: in SYNC, comma_cnt increments on each comma load. On the load edge where comma_cnt reaches MIN_COMMAS, state becomes RUN and active=1 from that edge onward.
  - RUN: terminal state; only reset leaves it.
  - A data byte can therefore first appear on the load edge 8 cycles after active rises.
- Holding register (1 entry):
  - ready_in = !hold_full | (load edge this cycle & state==RUN & hold_full), i.e. the byte being drained frees the slot in the same cycle.
  - Accept on valid_in & ready_in: hold_reg←data_in, hold_full←1.
  - Accept and drain in the same edge: the drained byte goes to shift_reg and the new byte stays in hold_reg, with hold_full remaining 1.
  - In SYNC, hold_reg may fill, but it is not drained until RUN.
- Throughput: at most 1 byte per 8 cycles. With continuous valid_in, ready_in is high exactly once per 8 cycles and the line carries back-to-back data bytes with no commas between them.
- Latency: a byte accepted when the slot is empty appears on data_out on the next load edge, 1..8 cycles later.
- A data byte equal to COMMA is sent with valid_out=1. The receiver cannot distinguish it from a comma on the line, so upstream must not send 0xBC while the receiver is aligning.
- valid_in while ready_in=0: the byte is ignored and not held. Upstream must keep it asserted until accepted.
- Reset asserted mid-byte: data_out goes to 0 immediately and any pending hold_reg byte is lost. After release, the preamble restarts from comma 1.

Test Plan:
- Reset release, valid_in=0 for 48 cycles:
  - data_out = 10111100 repeated 6 times starting on edge 1.
  - valid_out=0 throughout.
  - byte_start high after edges 1, 9, 17, 25, 33, 41.
  - active=1 from edge 25.
- data_in=8'hA5 offered at cycle 3 (during SYNC):
  - accepted at cycle 3; ready_in=0 thereafter.
  - Edges 1–32 carry commas.
  - Edges 33–40 carry 1,0,1,0,0,1,0,1 with valid_out=1.
  - ready_in returns to 1 after edge 33.
- Continuous valid_in with 8'h7E, 8'h2D, 8'hC6 after active:
  - three contiguous data bytes, 01111110 00101101 11000110.
  - valid_out=1 for 24 cycles, followed by commas with valid_out=0.
  - ready_in high exactly once per 8 cycles.
- data_in=8'hBC in RUN: line carries 10111100 with valid_out=1.
- reset_L pulsed low for 3 cycles at bit 4 of a data byte, with hold_full=1:
  - data_out=0, active=0, ready_in=1 during reset.
  - After release: 4 fresh commas, then active=1; the held byte is not sent.
- MIN_COMMAS=1: active=1 from edge 1, and the first data byte can appear at edge 9.

Source files
------------

// File: rtl/paralelo_serial_tx_if.sv
// Byte-side handshake and serial line-side signals of the parallel-to-serial transmitter.
// The master side drives bytes in and the slave side is the transmitter itself.
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic       data_out;
  logic       valid_out;
  logic       byte_start;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  ready_in,
    input  data_out,
    input  valid_out,
    input  byte_start,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_in,
    output data_out,
    output valid_out,
    output byte_start,
    output active
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: one-entry holding register feeding an MSB-first shifter,
// with comma fill when idle and a comma preamble after reset so the receiver can lock.
module paralelo_serial_tx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         MIN_COMMAS = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset_L,
  paralelo_serial_tx_if.slave   bus
);

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  localparam logic [3:0] LP_MIN_COMMAS = 4'(MIN_COMMAS);

  state_t     r_state;
  logic [7:0] r_shiftReg;
  logic [2:0] r_bitCnt;
  logic       r_holdFull;
  logic [7:0] r_holdReg;
  logic [3:0] r_commaCnt;
  logic       r_validOut;
  logic       r_byteStart;
  logic       r_active;

  logic       w_load;
  logic       w_drain;
  logic       w_ready;
  logic       w_accept;

  // bit counter starts at 0 so the first edge after reset already loads a comma
  assign w_load   = (r_bitCnt == 3'd0);
  assign w_drain  = w_load && (r_state == RUN) && r_holdFull;
  assign w_ready  = !r_holdFull || w_drain;
  assign w_accept = bus.valid_in && w_ready;

  assign bus.ready_in   = w_ready;
  assign bus.data_out   = r_shiftReg[7];
  assign bus.valid_out  = r_validOut;
  assign bus.byte_start = r_byteStart;
  assign bus.active     = r_active;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= SYNC;
      r_shiftReg  <= 8'h00;
      r_bitCnt    <= 3'd0;
      r_holdFull  <= 1'b0;
      r_holdReg   <= 8'h00;
      r_commaCnt  <= 4'd0;
      r_validOut  <= 1'b0;
      r_byteStart <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_byteStart <= w_load;

      if (w_load) begin
        r_bitCnt <= 3'd7;
        if (w_drain) begin
          r_shiftReg <= r_holdReg;
          r_validOut <= 1'b1;
        end else begin
          r_shiftReg <= COMMA;
          r_validOut <= 1'b0;
          // preamble: RUN is entered on the load that sends the last required comma
          if (r_state == SYNC) begin
            r_commaCnt <= r_commaCnt + 4'd1;
            if (r_commaCnt + 4'd1 == LP_MIN_COMMAS) begin
              r_state  <= RUN;
              r_active <= 1'b1;
            end
          end
        end
      end else begin
        r_bitCnt   <= r_bitCnt - 3'd1;
        r_shiftReg <= {r_shiftReg[6:0], 1'b0};
      end

      // a byte accepted on a drain edge refills the slot the drained byte just left
      if (w_accept) begin
        r_holdReg  <= bus.data_in;
        r_holdFull <= 1'b1;
      end else if (w_drain) begin
        r_holdFull <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: accepted bytes are queued with their accept edge and a
// line monitor predicts every byte slot (comma or data) from byte-slot arithmetic since reset.
module tb_paralelo_serial_tx;

  localparam int         MIN     = 4;
  localparam logic [7:0] COMMA_B = 8'hBC;

  typedef struct {
    logic [7:0] data;
    int         acceptEdge;
  } exp_t;

  logic clk_32f;
  logic reset_L;
  int   edgeCnt;
  int   total;
  int   bad;
  bit   m1Armed;

  exp_t q[$];
  int   dataStarts[$];

  paralelo_serial_tx_if bus ();
  paralelo_serial_tx_if bus1 ();

  paralelo_serial_tx #(.COMMA(8'hBC), .MIN_COMMAS(MIN)) u_dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  paralelo_serial_tx #(.COMMA(8'hBC), .MIN_COMMAS(1)) u_dutMin1 (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // edges since the last reset release; edge 1 is the first rising edge after release
  always @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) edgeCnt <= 0;
    else          edgeCnt <= edgeCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  // true when the transmitter is past its preamble after edge e
  function automatic bit runAfter(input int e);
    return (e >= 1) && (((e - 1) / 8 + 1) >= MIN);
  endfunction

  // one cycle of upstream drive, set just after the falling edge
  task automatic applyStimulus(input logic [7:0] d, input bit v, output bit acc);
    bit expReady;
    @(negedge clk_32f);
    #1;
    expReady = (q.size() == 0) ||
               ((q.size() == 1) && runAfter(edgeCnt) && (edgeCnt % 8 == 0));
    checkOutput("ready_in", bus.ready_in, expReady);
    bus.valid_in = v;
    bus.data_in  = d;
    acc = v && bus.ready_in;
    if (acc) q.push_back('{data: d, acceptEdge: edgeCnt + 1});
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, acc);
  endtask

  task automatic runUntilAccepted(input logic [7:0] d, output int accEdge);
    bit acc;
    acc = 1'b0;
    accEdge = -1;
    for (int i = 0; i < 40 && !acc; i++) begin
      applyStimulus(d, 1'b1, acc);
      if (acc) accEdge = edgeCnt + 1;
    end
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic resetDut();
    bus.valid_in = 1'b0;
    reset_L = 1'b0;
    q.delete();
    repeat (3) @(negedge clk_32f);
    #1;
    reset_L = 1'b1;
  endtask

  // line monitor: predicts each byte slot and checks every serial bit
  initial begin : monitor
    logic [7:0] curByte;
    bit         curValid;
    int         curBit;
    int         e;
    int         k;
    curByte  = COMMA_B;
    curValid = 1'b0;
    curBit   = 7;
    forever begin
      @(negedge clk_32f);
      if (!reset_L) begin
        checkOutput("rst_data_out", bus.data_out, 1'b0);
        checkOutput("rst_valid_out", bus.valid_out, 1'b0);
        checkOutput("rst_byte_start", bus.byte_start, 1'b0);
        checkOutput("rst_active", bus.active, 1'b0);
        checkOutput("rst_ready_in", bus.ready_in, 1'b1);
        curBit = 7;
      end else if (edgeCnt >= 1) begin
        e = edgeCnt;
        k = (e - 1) / 8 + 1;
        checkOutput("byte_start", bus.byte_start, (e % 8 == 1));
        checkOutput("active", bus.active, (k >= MIN));
        if (e % 8 == 1) begin
          if ((k > MIN) && (q.size() > 0) && (q[0].acceptEdge < e)) begin
            curByte  = q[0].data;
            curValid = 1'b1;
            void'(q.pop_front());
            dataStarts.push_back(e);
          end else begin
            curByte  = COMMA_B;
            curValid = 1'b0;
          end
          curBit = 7;
        end
        if (curBit >= 0) checkOutput("data_out", bus.data_out, curByte[curBit]);
        checkOutput("valid_out", bus.valid_out, curValid);
        curBit--;
      end
    end
  end

  // MIN_COMMAS=1 instance: RUN from edge 1, byte offered at release appears at edge 9
  initial begin : min1Check
    logic [7:0] b5a;
    int e;
    b5a = 8'h5A;
    forever begin
      @(negedge clk_32f);
      if (m1Armed && reset_L && edgeCnt >= 1) begin
        e = edgeCnt;
        if (e == 1) checkOutput("m1_active_edge1", bus1.active, 1'b1);
        if (e == 8) checkOutput("m1_first_comma_valid", bus1.valid_out, 1'b0);
        if (e == 9) checkOutput("m1_byte_start", bus1.byte_start, 1'b1);
        if (e >= 9 && e <= 16) begin
          checkOutput("m1_data_out", bus1.data_out, b5a[16 - e]);
          checkOutput("m1_valid_out", bus1.valid_out, 1'b1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int   ae;
    int   l;
    int   guard;
    logic [7:0] rd;
    bit   acc;
    total   = 0;
    bad     = 0;
    reset_L = 1'b0;
    m1Armed = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_in   = 8'h00;
    bus1.valid_in = 1'b0;
    bus1.data_in  = 8'h00;

    // idle after reset: six commas, active from edge 25; MIN_COMMAS=1 instance sends 0x5A
    $display("[TB] idle preamble");
    bus1.valid_in = 1'b1;
    bus1.data_in  = 8'h5A;
    m1Armed = 1'b1;
    resetDut();
    idle(1);
    bus1.valid_in = 1'b0;
    idle(47);
    m1Armed = 1'b0;
    checkOutput("idle_no_data", dataStarts.size(), 0);

    // byte offered during SYNC waits for the first RUN load at edge 33
    $display("[TB] byte during preamble");
    resetDut();
    dataStarts.delete();
    idle(1);
    runUntilAccepted(8'hA5, ae);
    checkOutput("sync_accept_edge", ae, 3);
    guard = 0;
    while (edgeCnt < 48 && guard < 60) begin idle(1); guard++; end
    checkOutput("sync_data_count", dataStarts.size(), 1);
    if (dataStarts.size() > 0) checkOutput("sync_data_edge", dataStarts[0], 33);

    // continuous valid: three back-to-back data bytes
    $display("[TB] back-to-back bytes");
    dataStarts.delete();
    runUntilAccepted(8'h7E, ae);
    runUntilAccepted(8'h2D, ae);
    runUntilAccepted(8'hC6, ae);
    idle(30);
    checkOutput("b2b_count", dataStarts.size(), 3);
    if (dataStarts.size() == 3) begin
      checkOutput("b2b_gap1", dataStarts[1] - dataStarts[0], 8);
      checkOutput("b2b_gap2", dataStarts[2] - dataStarts[1], 8);
    end

    // a data byte equal to the comma keeps valid_out high
    $display("[TB] comma-valued data");
    dataStarts.delete();
    runUntilAccepted(8'hBC, ae);
    idle(20);
    checkOutput("bc_data_count", dataStarts.size(), 1);

    // randomized traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 160; i++) begin
      rd = 8'($urandom);
      applyStimulus(rd, ($urandom_range(0, 3) != 0), acc);
    end
    idle(20);
    checkOutput("random_drained", q.size(), 0);

    // reset at bit 4 of a data byte while the slot holds another byte
    $display("[TB] reset mid-byte");
    runUntilAccepted(8'h3C, ae);
    runUntilAccepted(8'hE1, ae);
    l = ae;
    guard = 0;
    while (edgeCnt < l + 3 && guard < 20) begin idle(1); guard++; end
    #1;
    reset_L = 1'b0;
    q.delete();
    #1;
    checkOutput("async_rst_data_out", bus.data_out, 1'b0);
    checkOutput("async_rst_active", bus.active, 1'b0);
    checkOutput("async_rst_ready_in", bus.ready_in, 1'b1);
    repeat (3) @(negedge clk_32f);
    #1;
    reset_L = 1'b1;
    dataStarts.delete();
    idle(48);
    checkOutput("held_byte_lost", dataStarts.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
